// File: rtl/btn_gen_cfg_ctrl_if.sv
// Key/configuration bundle for btn_gen_cfg_ctrl.
//   btn_wave_i, btn_up_i, btn_down_i, btn_en_i : raw push-buttons, active high
//   wave_sel_o, freq_idx_o, gen_en_o           : current generator configuration
//   cfg_valid_o                                : one-cycle pulse when the configuration changed
// Modports: master drives the keys and observes the configuration; slave is the controller.
interface btn_gen_cfg_ctrl_if #(
  parameter int unsigned NUM_WAVE = 4,
  parameter int unsigned FREQ_W   = 4
);
  localparam int unsigned WAVE_W = $clog2(NUM_WAVE);

  logic              btn_wave_i;
  logic              btn_up_i;
  logic              btn_down_i;
  logic              btn_en_i;
  logic [WAVE_W-1:0] wave_sel_o;
  logic [FREQ_W-1:0] freq_idx_o;
  logic              gen_en_o;
  logic              cfg_valid_o;

  modport master (
    output btn_wave_i, btn_up_i, btn_down_i, btn_en_i,
    input  wave_sel_o, freq_idx_o, gen_en_o, cfg_valid_o
  );

  modport slave (
    input  btn_wave_i, btn_up_i, btn_down_i, btn_en_i,
    output wave_sel_o, freq_idx_o, gen_en_o, cfg_valid_o
  );
endinterface

// File: rtl/btn_gen_cfg_ctrl.sv
// Button-driven configuration controller for the test signal generator.
// Synchronises and debounces four raw keys, turns debounced rising edges into press events and
// sequences waveform select, saturating frequency index and output enable.
// Ports:
//   clk_i : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : btn_gen_cfg_ctrl_if.slave (raw keys in, configuration and cfg_valid_o out)
// Build option: define BTN_AUTOREPEAT_EN to give the up/down keys long-press auto-repeat
// (IDLE/HOLD/RPT per key). Without it each up/down press is exactly one step.
module btn_gen_cfg_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned HOLD_CYC     = 25000000,
  parameter int unsigned REPEAT_CYC   = 5000000,
  parameter int unsigned NUM_WAVE     = 4,
  parameter int unsigned FREQ_W       = 4,
  parameter int unsigned FREQ_RST     = 0
) (
  input logic                clk_i,
  input logic                rst_n,
  btn_gen_cfg_ctrl_if.slave  bus
);
  localparam int unsigned WaveW = $clog2(NUM_WAVE);
  localparam int unsigned DbW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  // Key bit positions
  localparam int unsigned KWave = 0;
  localparam int unsigned KEn   = 3;

  logic [3:0]          raw, sync1_q, sync2_q, db_q, db_d, db_prev_q, press;
  logic [3:0][DbW-1:0] cnt_q, cnt_d;
  logic [1:0]          step;  // [0] up, [1] down

  assign raw = {bus.btn_en_i, bus.btn_down_i, bus.btn_up_i, bus.btn_wave_i};

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int k = 0; k < 4; k++) begin
      if (sync2_q[k] != db_q[k]) begin
        if (cnt_q[k] == DbW'(DEBOUNCE_CYC - 1)) begin
          db_d[k] = ~db_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  assign press = db_q & ~db_prev_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned TmMax = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int unsigned TmW   = (TmMax > 1) ? $clog2(TmMax) : 1;

  typedef enum logic [1:0] {StIdle, StHold, StRpt} rpt_state_e;

  rpt_state_e          state_q [2];
  rpt_state_e          state_d [2];
  logic [1:0][TmW-1:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d = tmr_q;
    step  = '0;
    for (int j = 0; j < 2; j++) begin
      state_d[j] = state_q[j];
      unique case (state_q[j])
        StIdle: begin
          if (press[j+1]) begin
            step[j]    = 1'b1;
            tmr_d[j]   = '0;
            state_d[j] = StHold;
          end
        end
        StHold: begin
          if (!db_q[j+1]) begin
            state_d[j] = StIdle;
          end else if (tmr_q[j] == TmW'(HOLD_CYC - 1)) begin
            step[j]    = 1'b1;
            tmr_d[j]   = '0;
            state_d[j] = StRpt;
          end else begin
            tmr_d[j] = tmr_q[j] + 1'b1;
          end
        end
        StRpt: begin
          if (!db_q[j+1]) begin
            state_d[j] = StIdle;
          end else if (tmr_q[j] == TmW'(REPEAT_CYC - 1)) begin
            step[j]  = 1'b1;
            tmr_d[j] = '0;
          end else begin
            tmr_d[j] = tmr_q[j] + 1'b1;
          end
        end
        default: state_d[j] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0] <= StIdle;
      state_q[1] <= StIdle;
      tmr_q      <= '0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      tmr_q      <= tmr_d;
    end
  end
`else
  // Timing parameters only matter for auto-repeat.
  logic unused_params;
  assign unused_params = ^{HOLD_CYC, REPEAT_CYC};
  assign step = press[2:1];
`endif

  logic [WaveW-1:0]  wave_q, wave_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              en_q, en_d, valid_q, valid_d;

  always_comb begin
    wave_d = wave_q;
    freq_d = freq_q;
    en_d   = en_q ^ press[KEn];
    if (press[KWave]) begin
      wave_d = (wave_q == WaveW'(NUM_WAVE - 1)) ? '0 : wave_q + 1'b1;
    end
    // Simultaneous up+down cancel; steps past either end are dropped.
    if (step == 2'b01 && freq_q != '1) begin
      freq_d = freq_q + 1'b1;
    end else if (step == 2'b10 && freq_q != '0) begin
      freq_d = freq_q - 1'b1;
    end
    valid_d = (wave_d != wave_q) || (freq_d != freq_q) || (en_d != en_q);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wave_q  <= '0;
      freq_q  <= FREQ_W'(FREQ_RST);
      en_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      wave_q  <= wave_d;
      freq_q  <= freq_d;
      en_q    <= en_d;
      valid_q <= valid_d;
    end
  end

  assign bus.wave_sel_o  = wave_q;
  assign bus.freq_idx_o  = freq_q;
  assign bus.gen_en_o    = en_q;
  assign bus.cfg_valid_o = valid_q;
endmodule
